// File: rtl/sdrc_app_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller application request port
// among NREQ requesters; steers data handshakes to the owner until the last beat.
//
// state  | meaning
// IDLE   | searching m_req from rr_q; zero-length winners are rejected in place
// REQ    | app_req held with granted fields until app_req_ack
// DATA   | data handshakes steered to gnt_q until matching last beat or timeout
module sdrc_app_arbiter #(
  parameter int NREQ    = 4,
  parameter int APP_AW  = 26,
  parameter int APP_DW  = 32,
  parameter int APP_BW  = 4,
  parameter int APP_RW  = 9,
  parameter int TIMEOUT = 1023
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_rst,
  input  logic [NREQ-1:0]          m_req,
  input  logic [NREQ*APP_AW-1:0]   m_req_addr,
  input  logic [NREQ*APP_RW-1:0]   m_req_len,
  input  logic [NREQ-1:0]          m_req_wr_n,
  input  logic [NREQ*APP_DW-1:0]   m_wr_data,
  input  logic [NREQ*APP_BW-1:0]   m_wr_en_n,
  output logic [NREQ-1:0]          m_req_ack,
  output logic [NREQ-1:0]          m_wr_next,
  output logic [NREQ-1:0]          m_rd_valid,
  output logic [NREQ-1:0]          m_last,
  output logic [NREQ-1:0]          m_err,
  output logic [APP_DW-1:0]        m_rd_data,
  output logic                     app_req,
  output logic [APP_AW-1:0]        app_req_addr,
  output logic [APP_RW-1:0]        app_req_len,
  output logic                     app_req_wr_n,
  input  logic                     app_req_ack,
  output logic [APP_DW-1:0]        app_wr_data,
  output logic [APP_BW-1:0]        app_wr_en_n,
  input  logic                     app_wr_next_req,
  input  logic [APP_DW-1:0]        app_rd_data,
  input  logic                     app_rd_valid,
  input  logic                     app_last_wr,
  input  logic                     app_last_rd
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [APP_RW-1:0] len_q, len_d;
  logic              wr_n_q, wr_n_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   zack_q, zack_d;

  logic [NREQ-1:0]   req_eff;
  logic              hit;
  logic [GW-1:0]     win;
  logic [APP_RW-1:0] win_len;
  logic              last_ok;
  logic              tmo;

  function automatic logic [GW-1:0] ptr_inc(input logic [GW-1:0] p);
    if (int'(p) == NREQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // A rejected requester still holds m_req in its ack cycle; mask it so it is not rejected twice.
  assign req_eff = m_req & ~zack_q;

  always_comb begin : p_search
    int idx;
    idx = 0;
    hit = 1'b0;
    win = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!hit && req_eff[idx]) begin
        hit = 1'b1;
        win = GW'(idx);
      end
    end
  end

  assign win_len = m_req_len[int'(win)*APP_RW +: APP_RW];
  assign last_ok = wr_n_q ? app_last_rd : app_last_wr;
  assign tmo     = (state_q == S_DATA) && (cnt_q == '0) && !last_ok;

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      wr_n_q  <= 1'b0;
      cnt_q   <= '0;
      zack_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wr_n_q  <= wr_n_d;
      cnt_q   <= cnt_d;
      zack_q  <= zack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wr_n_d  = wr_n_q;
    cnt_d   = cnt_q;
    zack_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          if (win_len == '0) begin
            zack_d[win] = 1'b1;
            rr_d        = ptr_inc(win);
          end else begin
            gnt_d   = win;
            addr_d  = m_req_addr[int'(win)*APP_AW +: APP_AW];
            len_d   = win_len;
            wr_n_d  = m_req_wr_n[win];
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (app_req_ack) begin
          state_d = S_DATA;
          rr_d    = ptr_inc(gnt_q);
          cnt_d   = CW'(TIMEOUT);
        end
      end
      S_DATA: begin
        // Down-counter reaches zero on the TIMEOUT-th cycle after DATA entry.
        if (last_ok || tmo) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_req_ack   = zack_q;
    m_err       = zack_q;
    m_wr_next   = '0;
    m_rd_valid  = '0;
    m_last      = '0;
    app_wr_en_n = '1;
    if (state_q == S_REQ) m_req_ack[gnt_q] = app_req_ack;
    if (state_q == S_DATA) begin
      m_wr_next[gnt_q]  = app_wr_next_req;
      m_rd_valid[gnt_q] = app_rd_valid;
      m_last[gnt_q]     = app_last_wr | app_last_rd;
      m_err[gnt_q]      = tmo;
      app_wr_en_n       = m_wr_en_n[int'(gnt_q)*APP_BW +: APP_BW];
    end
  end

  assign app_req      = (state_q == S_REQ);
  assign app_req_addr = addr_q;
  assign app_req_len  = len_q;
  assign app_req_wr_n = wr_n_q;
  assign app_wr_data  = m_wr_data[int'(gnt_q)*APP_DW +: APP_DW];
  assign m_rd_data    = app_rd_data;

endmodule

// File: tb/tb_sdrc_app_arbiter.sv
// Scoreboard bench for sdrc_app_arbiter: directed stimulus pushes expected events,
// a negedge monitor pops and compares every event the DUT presents.
module tb_sdrc_app_arbiter;
  localparam int NREQ = 4, AW = 26, DW = 32, BW = 4, RW = 9, TMO = 15;

  logic               sdram_clk = 1'b0;
  logic               sdram_rst;
  logic [NREQ-1:0]    m_req;
  logic [NREQ*AW-1:0] m_req_addr;
  logic [NREQ*RW-1:0] m_req_len;
  logic [NREQ-1:0]    m_req_wr_n;
  logic [NREQ*DW-1:0] m_wr_data;
  logic [NREQ*BW-1:0] m_wr_en_n;
  logic [NREQ-1:0]    m_req_ack, m_wr_next, m_rd_valid, m_last, m_err;
  logic [DW-1:0]      m_rd_data;
  logic               app_req;
  logic [AW-1:0]      app_req_addr;
  logic [RW-1:0]      app_req_len;
  logic               app_req_wr_n;
  logic               app_req_ack;
  logic [DW-1:0]      app_wr_data;
  logic [BW-1:0]      app_wr_en_n;
  logic               app_wr_next_req;
  logic [DW-1:0]      app_rd_data;
  logic               app_rd_valid, app_last_wr, app_last_rd;

  always #5 sdram_clk = ~sdram_clk;

  sdrc_app_arbiter #(.NREQ(NREQ), .APP_AW(AW), .APP_DW(DW), .APP_BW(BW),
                     .APP_RW(RW), .TIMEOUT(TMO)) dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
    .m_req(m_req), .m_req_addr(m_req_addr), .m_req_len(m_req_len),
    .m_req_wr_n(m_req_wr_n), .m_wr_data(m_wr_data), .m_wr_en_n(m_wr_en_n),
    .m_req_ack(m_req_ack), .m_wr_next(m_wr_next), .m_rd_valid(m_rd_valid),
    .m_last(m_last), .m_err(m_err), .m_rd_data(m_rd_data),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next_req(app_wr_next_req), .app_rd_data(app_rd_data),
    .app_rd_valid(app_rd_valid), .app_last_wr(app_last_wr), .app_last_rd(app_last_rd)
  );

  int cyc = 0;
  always @(posedge sdram_clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  typedef struct {int kind; logic [63:0] val; int cyc;} exp_t;
  exp_t exp_q[$];

  logic [AW-1:0] r_addr [NREQ];
  logic [RW-1:0] r_len  [NREQ];
  logic          r_wrn  [NREQ];
  logic [DW-1:0] wdat   [NREQ];
  logic [BW-1:0] wen    [NREQ];

  function automatic string kname(int k);
    case (k)
      0: return "grant";
      1: return "req_ack";
      2: return "err";
      3: return "rd_beat";
      4: return "wr_beat";
      default: return "event";
    endcase
  endfunction

  function automatic void push(int k, logic [63:0] v, int c);
    exp_t e;
    e.kind = k; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  task automatic check_ev(int k, logic [63:0] v);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got val=%h cyc=%0d, required no event", kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || (e.cyc >= 0 && e.cyc != cyc)) begin
        miscompares++;
        $display("FAIL %s: got kind=%0d val=%h cyc=%0d, required kind=%0d val=%h cyc=%0d",
                 kname(e.kind), k, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  logic req_prev = 1'b0;
  always @(negedge sdram_clk) begin
    if (app_req && !req_prev) check_ev(0, 64'({app_req_wr_n, app_req_len, app_req_addr}));
    if (m_req_ack != '0)      check_ev(1, 64'(m_req_ack));
    if (m_err != '0)          check_ev(2, 64'(m_err));
    if (m_rd_valid != '0)     check_ev(3, 64'({m_rd_valid, m_last, m_rd_data}));
    if (m_wr_next != '0)      check_ev(4, 64'({m_wr_next, m_last, app_wr_en_n, app_wr_data}));
    req_prev = app_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(int r, logic [AW-1:0] a, logic [RW-1:0] l, logic wn);
    r_addr[r] = a; r_len[r] = l; r_wrn[r] = wn;
    m_req_addr[r*AW +: AW] = a;
    m_req_len[r*RW +: RW]  = l;
    m_req_wr_n[r]          = wn;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (app_req) begin
        got = 1'b1;
        break;
      end
      @(posedge sdram_clk); #1;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL app_req_wait: app_req=0 after 40 cycles, required 1");
      exp_q.delete();
    end
  endtask

  // Controller model: acks the request, then drives beats (beats<0: none, forcing timeout).
  task automatic ctrl_burst(int o, bit is_wr, int beats, int gcyc, logic [3:0] clr, int wrongbeat);
    bit got;
    int ackc;
    logic [3:0] oh;
    oh = 4'(1 << o);
    push(0, 64'({r_wrn[o], r_len[o], r_addr[o]}), gcyc);
    wait_req(got);
    if (!got) return;
    ackc = cyc;
    push(1, 64'(oh), ackc);
    app_req_ack = 1'b1;
    @(posedge sdram_clk); #1;
    app_req_ack = 1'b0;
    m_req = m_req & ~clr;
    if (beats < 0) begin
      push(2, 64'(oh), ackc + TMO + 1);
      repeat (TMO + 1) @(posedge sdram_clk);
      #1;
      return;
    end
    for (int b = 1; b <= beats; b++) begin
      if (is_wr) begin
        app_wr_next_req = 1'b1;
        app_last_wr     = (b == beats);
        push(4, 64'({oh, (b == beats) ? oh : 4'b0, wen[o], wdat[o]}), cyc);
      end else begin
        app_rd_valid = 1'b1;
        app_rd_data  = 32'hD000_0000 | 32'(o << 8) | 32'(b);
        app_last_rd  = (b == beats);
        app_last_wr  = (b == wrongbeat);
        push(3, 64'({oh, (b == beats || b == wrongbeat) ? oh : 4'b0, app_rd_data}), cyc);
      end
      @(posedge sdram_clk); #1;
    end
    app_wr_next_req = 1'b0; app_last_wr = 1'b0;
    app_rd_valid = 1'b0; app_last_rd = 1'b0; app_rd_data = '0;
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_app_req"},   64'(app_req), 64'(0));
    chk({tag, "_addr"},      64'(app_req_addr), 64'(0));
    chk({tag, "_len"},       64'(app_req_len), 64'(0));
    chk({tag, "_wr_n"},      64'(app_req_wr_n), 64'(0));
    chk({tag, "_req_ack"},   64'(m_req_ack), 64'(0));
    chk({tag, "_err"},       64'(m_err), 64'(0));
    chk({tag, "_wr_next"},   64'(m_wr_next), 64'(0));
    chk({tag, "_rd_valid"},  64'(m_rd_valid), 64'(0));
    chk({tag, "_last"},      64'(m_last), 64'(0));
    chk({tag, "_wr_en_n"},   64'(app_wr_en_n), 64'(4'hF));
    chk({tag, "_wr_data"},   64'(app_wr_data), 64'(wdat[0]));
  endtask

  initial begin
    int n0;
    bit got;
    sdram_rst = 1'b1;
    m_req = '0; m_req_addr = '0; m_req_len = '0; m_req_wr_n = '0;
    app_req_ack = 1'b0; app_wr_next_req = 1'b0; app_rd_data = '0;
    app_rd_valid = 1'b0; app_last_wr = 1'b0; app_last_rd = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      wdat[r] = 32'hA5A5_0000 | 32'(r * 17);
      wen[r]  = 4'(r * 3 + 1);
      m_wr_data[r*DW +: DW] = wdat[r];
      m_wr_en_n[r*BW +: BW] = wen[r];
      set_req(r, '0, '0, 1'b0);
    end
    repeat (3) @(posedge sdram_clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_rd_data", 64'(m_rd_data), 64'(0));
    sdram_rst = 1'b0;
    @(posedge sdram_clk); #1;

    // round robin, all four held, single-beat bursts: order 0,1,2,3,0
    set_req(0, 26'h0000100, 9'd1, 1'b0);
    set_req(1, 26'h0000200, 9'd1, 1'b1);
    set_req(2, 26'h0000300, 9'd1, 1'b0);
    set_req(3, 26'h0000400, 9'd1, 1'b1);
    m_req = 4'hF;
    ctrl_burst(0, 1'b1, 1, cyc + 1, 4'h0, 0);
    ctrl_burst(1, 1'b0, 1, cyc + 1, 4'h0, 0);
    ctrl_burst(2, 1'b1, 1, cyc + 1, 4'h0, 0);
    ctrl_burst(3, 1'b0, 1, cyc + 1, 4'h0, 0);
    ctrl_burst(0, 1'b1, 1, cyc + 1, 4'hF, 0);

    // single write, len 4
    set_req(0, 26'h0001000, 9'd4, 1'b0);
    m_req = 4'b0001;
    ctrl_burst(0, 1'b1, 4, cyc + 1, 4'b0001, 0);

    // zero length from 1 while 2 is pending: reject 1, grant 2 next
    set_req(1, 26'h0002000, 9'd0, 1'b0);
    set_req(2, 26'h0003000, 9'd2, 1'b1);
    m_req = 4'b0110;
    n0 = cyc;
    push(1, 64'(4'b0010), n0 + 1);
    push(2, 64'(4'b0010), n0 + 1);
    @(posedge sdram_clk); #1;
    ctrl_burst(2, 1'b0, 2, n0 + 2, 4'b0110, 0);

    // zero length alone: exactly one ack/err pulse even though m_req lingers a cycle
    m_req = 4'b0010;
    n0 = cyc;
    push(1, 64'(4'b0010), n0 + 1);
    push(2, 64'(4'b0010), n0 + 1);
    @(posedge sdram_clk); #1;
    @(posedge sdram_clk); #1;
    m_req = '0;
    repeat (3) @(posedge sdram_clk);
    #1;

    // read steering to requester 2, len 8, wrong-direction last on beat 4 ignored
    set_req(2, 26'h0004000, 9'd8, 1'b1);
    m_req = 4'b0100;
    ctrl_burst(2, 1'b0, 8, cyc + 1, 4'b0100, 4);

    // timeout on requester 3, then a fresh grant with 1-cycle latency
    set_req(3, 26'h3FFFFC0, 9'd5, 1'b0);
    m_req = 4'b1000;
    ctrl_burst(3, 1'b1, -1, cyc + 1, 4'b1000, 0);
    set_req(0, 26'h0005000, 9'd1, 1'b0);
    m_req = 4'b0001;
    ctrl_burst(0, 1'b1, 1, cyc + 1, 4'b0001, 0);

    // reset after beat 2 of 4; rr pointer must restart at 0
    set_req(2, 26'h0006000, 9'd4, 1'b0);
    m_req = 4'b0100;
    push(0, 64'({r_wrn[2], r_len[2], r_addr[2]}), cyc + 1);
    wait_req(got);
    if (got) begin
      push(1, 64'(4'b0100), cyc);
      app_req_ack = 1'b1;
      @(posedge sdram_clk); #1;
      app_req_ack = 1'b0;
      m_req = '0;
      for (int b = 1; b <= 2; b++) begin
        app_wr_next_req = 1'b1;
        push(4, 64'({4'b0100, 4'b0000, wen[2], wdat[2]}), cyc);
        @(posedge sdram_clk); #1;
      end
      app_wr_next_req = 1'b0;
      sdram_rst = 1'b1;
      @(posedge sdram_clk); #1;
      check_idle_outputs("midrst");
      sdram_rst = 1'b0;
    end
    set_req(1, 26'h0007000, 9'd2, 1'b1);
    set_req(3, 26'h0008000, 9'd1, 1'b0);
    m_req = 4'b1010;
    ctrl_burst(1, 1'b0, 2, cyc + 1, 4'b0010, 0);
    ctrl_burst(3, 1'b1, 1, cyc + 1, 4'b1000, 0);
    m_req = '0;

    repeat (4) @(posedge sdram_clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_events: got %0d pending, required 0 (next kind=%0d)",
               exp_q.size(), exp_q[0].kind);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
